// File: rtl/lsu_port.sv
// Single-outstanding load/store port: aligns, lane-shifts and extends accesses.
// Optional BUSY watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_port #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ena,
  output logic        mem_wen,
  output logic [3:0]  mem_mask,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic        wen_q, uns_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q, wdata_q;
  logic        mis, expired, busy;
  logic [5:0]  shift;
  logic [63:0] rd_sh, ld;
  logic [3:0]  mask;

  assign busy  = (state == BUSY);
  assign shift = {addr_q[2:0], 3'b000};
  assign rd_sh = mem_rdata >> shift;

  always_comb begin
    mis = 1'b0;
    unique case (req_size)
      2'd1:    mis = req_addr[0];
      2'd2:    mis = |req_addr[1:0];
      2'd3:    mis = |req_addr[2:0];
      default: mis = 1'b0;
    endcase
  end

  always_comb begin
    ld   = rd_sh;
    mask = 4'b0001;
    unique case (size_q)
      2'd0: begin
        mask = 4'b1000;
        ld   = {{56{rd_sh[7] & ~uns_q}}, rd_sh[7:0]};
      end
      2'd1: begin
        mask = 4'b0100;
        ld   = {{48{rd_sh[15] & ~uns_q}}, rd_sh[15:0]};
      end
      2'd2: begin
        mask = 4'b0010;
        ld   = {{32{rd_sh[31] & ~uns_q}}, rd_sh[31:0]};
      end
      default: begin
        mask = 4'b0001;
        ld   = rd_sh;
      end
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (busy) cnt <= cnt + 32'd1;
    else           cnt <= '0;
  end

  assign expired = busy && (cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = mis ? RESP : BUSY;
      BUSY:    if (mem_ack || expired) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wen_q      <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        wen_q      <= req_wen;
        uns_q      <= req_unsigned;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= mis;
      end else if (busy && mem_ack) begin
        resp_rdata <= wen_q ? 64'd0 : ld;
        resp_err   <= 1'b0;
      end else if (expired) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_ena    = busy;
  assign mem_wen    = busy & wen_q;
  assign mem_mask   = busy ? mask : 4'b0000;
  assign mem_addr   = addr_q;
  assign mem_wdata  = busy ? (wdata_q << shift) : 64'd0;

endmodule
